// File: rtl/forwarded_value_tracker.sv
// Destination-domain consumer for a CDC data forwarder: qualifies stable values, publishes them with a
// strobe, counts updates and flags a stale source. Define FWD_TRACKER_DELTA_EN to enable the delta output.
module forwarded_value_tracker #(
   parameter int DATA_WIDTH    = 32,
   parameter int STABLE_COUNT  = 2,
   parameter int STALE_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] inData,
   output logic [DATA_WIDTH-1:0] valueOut,
   output logic                  valueStrobe,
   output logic                  valueValid,
   output logic [15:0]           updateCount,
   output logic                  stale,
   output logic [DATA_WIDTH-1:0] delta
);

   localparam int CNT_W  = $clog2(STABLE_COUNT + 1);
   localparam int IDLE_W = $clog2(STALE_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_COUNT);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_TRACK = 2'd1,
      ST_STALE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] wrap_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
      return a - b;
   endfunction

   logic [DATA_WIDTH-1:0] sample_q, sample_d;
   logic [DATA_WIDTH-1:0] candidate_q, candidate_d;
   logic [CNT_W-1:0]      stable_cnt_q, stable_cnt_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  strobe_q, strobe_d;
   logic                  valid_q, valid_d;
   logic [15:0]           count_q, count_d;
   logic                  stale_q, stale_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   state_t                state_q, state_d;
   logic                  publish;

   always_comb begin
      sample_d     = inData;
      candidate_d  = candidate_q;
      stable_cnt_d = stable_cnt_q;
      if (sample_q != candidate_q) begin
         candidate_d  = sample_q;
         stable_cnt_d = CNT_W'(1);
      end else begin
         stable_cnt_d = sat_inc(stable_cnt_q);
      end
   end

   // A held or re-forwarded copy of the published value never republishes; before the first
   // publish any qualified value (including 0) is taken.
   assign publish = (stable_cnt_q == CNT_MAX) && (!valid_q || (candidate_q != value_q));

   always_comb begin
      value_d  = value_q;
      strobe_d = publish;
      valid_d  = valid_q | publish;
      count_d  = count_q + 16'(publish);
      stale_d  = stale_q;
      idle_d   = idle_q;
      state_d  = state_q;
      if (publish) begin
         value_d = candidate_q;
         state_d = ST_TRACK;
         idle_d  = '0;
         stale_d = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY, ST_TRACK: begin
               if (idle_q == IDLE_MAX) begin
                  state_d = ST_STALE;
                  stale_d = 1'b1;
               end else begin
                  idle_d = idle_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_STALE;
               stale_d = 1'b1;
            end
         endcase
      end
   end

`ifdef FWD_TRACKER_DELTA_EN
   logic [DATA_WIDTH-1:0] delta_q, delta_d;

   always_comb begin
      delta_d = delta_q;
      if (publish) begin
         delta_d = valid_q ? wrap_sub(candidate_q, value_q) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta_q <= '0;
      end else begin
         delta_q <= delta_d;
      end
   end

   assign delta = delta_q;
`else
   assign delta = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q     <= '0;
         candidate_q  <= '0;
         stable_cnt_q <= '0;
         value_q      <= '0;
         strobe_q     <= 1'b0;
         valid_q      <= 1'b0;
         count_q      <= '0;
         stale_q      <= 1'b0;
         idle_q       <= '0;
         state_q      <= ST_EMPTY;
      end else begin
         sample_q     <= sample_d;
         candidate_q  <= candidate_d;
         stable_cnt_q <= stable_cnt_d;
         value_q      <= value_d;
         strobe_q     <= strobe_d;
         valid_q      <= valid_d;
         count_q      <= count_d;
         stale_q      <= stale_d;
         idle_q       <= idle_d;
         state_q      <= state_d;
      end
   end

   assign valueOut    = value_q;
   assign valueStrobe = strobe_q;
   assign valueValid  = valid_q;
   assign updateCount = count_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_forwarded_value_tracker.sv
// Bench for forwarded_value_tracker: reset/first-zero vector table, glitch/stale/race/delta sequences,
// randomized run against a sample-history reference model, and a 16-bit update counter wrap.
module tb_forwarded_value_tracker;

   localparam int DW = 32;
   localparam int SC = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] in_data = 32'h1234;
   logic [DW-1:0] a_value_out, a_delta;
   logic          a_strobe, a_valid, a_stale;
   logic [15:0]   a_count;

   logic          rst_b = 1'b1;
   logic [DW-1:0] in_b = '0;
   logic [DW-1:0] b_value_out, b_delta;
   logic          b_strobe, b_valid, b_stale;
   logic [15:0]   b_count;

   always #5 clk = ~clk;

   forwarded_value_tracker #(.DATA_WIDTH(DW), .STABLE_COUNT(SC), .STALE_TIMEOUT(TO)) dut_a (
      .clk(clk), .rst_n(rst_n), .inData(in_data), .valueOut(a_value_out), .valueStrobe(a_strobe),
      .valueValid(a_valid), .updateCount(a_count), .stale(a_stale), .delta(a_delta));

   forwarded_value_tracker #(.DATA_WIDTH(DW), .STABLE_COUNT(1), .STALE_TIMEOUT(1024)) dut_b (
      .clk(clk), .rst_n(rst_b), .inData(in_b), .valueOut(b_value_out), .valueStrobe(b_strobe),
      .valueValid(b_valid), .updateCount(b_count), .stale(b_stale), .delta(b_delta));

   int checks = 0;
   int errors = 0;
   int seen_strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: a value is published once it has been seen for SC consecutive samples
   // ending two edges ago and differs from the last published value (or nothing was published).
   logic [DW-1:0] mq_val[$];
   int            mq_run[$];
   logic [DW-1:0] m_vout, m_delta;
   logic          m_strobe, m_valid, m_stale;
   logic [15:0]   m_cnt;
   int            m_since;

   function automatic void model_reset();
      mq_val = {32'h0, 32'h0};
      mq_run = {0, 1};
      m_vout = '0; m_delta = '0; m_strobe = 1'b0; m_valid = 1'b0;
      m_stale = 1'b0; m_cnt = '0; m_since = 0;
   endfunction

   function automatic void model_step(input logic [DW-1:0] din);
      logic pub;
      int   r;
      pub = (mq_run[0] >= SC) && (!m_valid || (mq_val[0] != m_vout));
      if (pub) begin
`ifdef FWD_TRACKER_DELTA_EN
         m_delta = m_valid ? (mq_val[0] - m_vout) : 32'h0;
`endif
         m_vout  = mq_val[0];
         m_valid = 1'b1;
         m_cnt   = m_cnt + 16'd1;
         m_since = 0;
         m_stale = 1'b0;
      end else begin
         if (m_since < TO) m_since++;
         m_stale = (m_since >= TO);
      end
      m_strobe = pub;
      r = (din == mq_val[1]) ? mq_run[1] + 1 : 1;
      if (r > SC) r = SC;
      mq_val.push_back(din);
      mq_run.push_back(r);
      void'(mq_val.pop_front());
      void'(mq_run.pop_front());
   endfunction

   task automatic compare_model();
      check("model.valueOut", a_value_out, m_vout);
      check("model.valueStrobe", a_strobe, m_strobe);
      check("model.valueValid", a_valid, m_valid);
      check("model.updateCount", a_count, m_cnt);
      check("model.stale", a_stale, m_stale);
      check("model.delta", a_delta, m_delta);
   endtask

   task automatic tick(input logic [DW-1:0] v);
      in_data = v;
      @(posedge clk);
      model_step(v);
      #1;
      if (a_strobe) seen_strobes++;
      compare_model();
   endtask

   task automatic do_reset(input logic [DW-1:0] v);
      in_data = v;
      rst_n = 1'b0;
      #1;
      check("rst.valueOut", a_value_out, 0);
      check("rst.strobe_valid_stale", {a_strobe, a_valid, a_stale}, 0);
      check("rst.updateCount", a_count, 0);
      check("rst.delta", a_delta, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_until_strobe(input logic [DW-1:0] v, input int max, input string name,
                                   output int n);
      n = 0;
      do begin
         tick(v);
         n++;
      end while (!a_strobe && n < max);
      check({name, ".strobe"}, a_strobe, 1);
   endtask

   typedef struct {
      logic          rst_n;
      logic [DW-1:0] din;
      logic [DW-1:0] vout;
      logic          strobe;
      logic          valid;
      logic [15:0]   cnt;
      logic          stale;
   } vec_t;

   vec_t tbl[$];

   function automatic void add_vec(input logic r, input logic [DW-1:0] d, input logic [DW-1:0] vo,
                                   input logic s, input logic va, input logic [15:0] c,
                                   input logic st);
      vec_t e;
      e.rst_n = r; e.din = d; e.vout = vo; e.strobe = s; e.valid = va; e.cnt = c; e.stale = st;
      tbl.push_back(e);
   endfunction

   initial begin
      #20_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s0;
      int nb;
      int guard;

      // Reset with 0x1234 forwarded, then a 4-edge publish; then reset with 0 held.
      add_vec(0, 32'h1234, 0, 0, 0, 0, 0);
      add_vec(0, 32'h1234, 0, 0, 0, 0, 0);
      add_vec(1, 32'h1234, 0, 0, 0, 0, 0);
      add_vec(1, 32'h1234, 0, 0, 0, 0, 0);
      add_vec(1, 32'h1234, 0, 0, 0, 0, 0);
      add_vec(1, 32'h1234, 32'h1234, 1, 1, 1, 0);
      add_vec(1, 32'h1234, 32'h1234, 0, 1, 1, 0);
      add_vec(1, 32'h1234, 32'h1234, 0, 1, 1, 0);
      add_vec(0, 32'h0, 0, 0, 0, 0, 0);
      add_vec(1, 32'h0, 0, 0, 0, 0, 0);
      add_vec(1, 32'h0, 0, 0, 0, 0, 0);
      add_vec(1, 32'h0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 4; i++) add_vec(1, 32'h0, 0, 0, 1, 1, 0);

      #1;
      rst_n = 1'b0;
      rst_b = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         rst_n   = tbl[i].rst_n;
         in_data = tbl[i].din;
         @(posedge clk);
         #1;
         check("tbl.valueOut", a_value_out, tbl[i].vout);
         check("tbl.valueStrobe", a_strobe, tbl[i].strobe);
         check("tbl.valueValid", a_valid, tbl[i].valid);
         check("tbl.updateCount", a_count, tbl[i].cnt);
         check("tbl.stale", a_stale, tbl[i].stale);
         check("tbl.delta", a_delta, 0);
      end

      // Glitch rejection, then a real change.
      do_reset(32'h10);
      repeat (6) tick(32'h10);
      check("glitch.first_value", a_value_out, 32'h10);
      s0 = seen_strobes;
      tick(32'h20);
      repeat (6) tick(32'h10);
      check("glitch.no_strobe", seen_strobes - s0, 0);
      s0 = seen_strobes;
      repeat (6) tick(32'h30);
      check("glitch.one_strobe", seen_strobes - s0, 1);
      check("glitch.value", a_value_out, 32'h30);

      // Latency and stale timeout.
      run_until_strobe(32'h44, 10, "stale.pub", n);
      check("latency.edges", n, SC + 2);
      n = 0;
      do begin
         tick(32'h44);
         n++;
      end while (!a_stale && n < 40);
      check("stale.edges", n, TO);
      tick(32'h55);
      check("stale.held", a_stale, 1);
      run_until_strobe(32'h55, 10, "stale.clear_pub", n);
      check("stale.cleared", a_stale, 0);
      check("stale.clear_value", a_value_out, 32'h55);

      // Publish lands on the timeout edge: publish wins and the idle timer restarts.
      repeat (TO - 4) tick(32'h55);
      run_until_strobe(32'h66, 10, "race.pub", n);
      check("race.latency", n, SC + 2);
      check("race.stale_low", a_stale, 0);
      n = 0;
      do begin
         tick(32'h66);
         n++;
      end while (!a_stale && n < 40);
      check("race.restart_edges", n, TO);

      // Delta between consecutive publishes.
      run_until_strobe(32'h5, 10, "delta.pub5", n);
      run_until_strobe(32'h3, 10, "delta.pub3", n);
`ifdef FWD_TRACKER_DELTA_EN
      check("delta.value", a_delta, 32'hFFFF_FFFE);
`else
      check("delta.value", a_delta, 32'h0);
`endif

      // Reset mid-qualification discards the pending candidate.
      tick(32'h77);
      tick(32'h77);
      do_reset(32'h0);
      run_until_strobe(32'h0, 8, "midrst.pub", n);
      check("midrst.latency", n, 3);
      check("midrst.value", a_value_out, 32'h0);
      s0 = seen_strobes;
      repeat (8) tick(32'h0);
      check("midrst.no_more", seen_strobes - s0, 0);

      // Randomized holds, glitches, long idles and resets.
      for (int seg = 0; seg < 400; seg++) begin
         int            len;
         logic [DW-1:0] v;
         if ($urandom_range(0, 49) == 0) begin
            do_reset($urandom);
         end else begin
            case ($urandom_range(0, 3))
               0:       v = 32'h0;
               1:       v = 32'($urandom_range(1, 3));
               default: v = $urandom;
            endcase
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 22))
                                              : int'($urandom_range(1, 5));
            repeat (len) tick(v);
         end
      end

      // updateCount wrap on the single-sample-qualification instance.
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      nb = 0;
      guard = 0;
      while (nb < 65536 && guard < 70000) begin
         in_b = 32'(guard + 1);
         @(posedge clk);
         #1;
         guard++;
         if (b_strobe) begin
            nb++;
            if (nb == 65535) check("wrap.ffff", b_count, 16'hFFFF);
         end
      end
      check("wrap.total", nb, 65536);
      check("wrap.zero", b_count, 16'h0000);
      check("wrap.value", b_value_out, 32'(guard - 2));
      check("wrap.valid_stale", {b_valid, b_stale}, 2'b10);
`ifdef FWD_TRACKER_DELTA_EN
      check("wrap.delta", b_delta, 32'h1);
`else
      check("wrap.delta", b_delta, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
